// File: rtl/mult_acc_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mult_acc_stage: registers multiplier products, optionally accumulates them,  |
// | flags overflow, and buffers results in an in-order valid/ready FIFO.         |
// | Optional: define MULT_ACC_SAT_EN to saturate on accumulate overflow.         |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module mult_acc_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [WIDTH-1:0]           Product,
  input  logic                       ProductOvf,
  input  logic                       Accumulate,
  input  logic                       ClearSticky,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [WIDTH-1:0]           Result,
  output logic                       ResultOvf,
  output logic                       StickyOvf,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_ovf  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             sticky;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] acc_next;
  logic             entry_ovf;

  assign InReady = (count < CW'(DEPTH));
  assign OutValid = (count != '0);
  assign accept = InValid && InReady;
  assign pop = OutValid && OutReady;

  assign sum = acc + Product;
  // Same-sign operands whose sum flips sign have left the representable range.
  assign add_ovf = Accumulate && (acc[WIDTH-1] == Product[WIDTH-1]) &&
                   (sum[WIDTH-1] != acc[WIDTH-1]);
  assign entry_ovf = ProductOvf | add_ovf;

  always_comb begin
    acc_next = Accumulate ? sum : Product;
`ifdef MULT_ACC_SAT_EN
    if (add_ovf) begin
      acc_next = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset && accept) begin
      mem_data[wr_ptr] <= acc_next;
      mem_ovf[wr_ptr]  <= entry_ovf;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sticky <= 1'b0;
    end else begin
      if (accept) begin
        acc    <= acc_next;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (accept && entry_ovf) begin
        sticky <= 1'b1;
      end else if (ClearSticky) begin
        sticky <= 1'b0;
      end
    end
  end

  assign Result    = OutValid ? mem_data[rd_ptr] : '0;
  assign ResultOvf = OutValid ? mem_ovf[rd_ptr] : 1'b0;
  assign StickyOvf = sticky;
  assign Count     = count;

endmodule
`default_nettype wire

// File: tb/tb_mult_acc_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mult_acc_stage: directed self-checking bench for mult_acc_stage.          |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_mult_acc_stage;

  logic        Clk = 1'b0;
  logic        Reset, InValid, ProductOvf, Accumulate, ClearSticky, OutReady;
  logic [31:0] Product;
  logic        InReady, OutValid, ResultOvf, StickyOvf;
  logic [31:0] Result;
  logic [1:0]  Count;

  int total = 0;
  int bad = 0;

  mult_acc_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Product(Product), .ProductOvf(ProductOvf), .Accumulate(Accumulate),
    .ClearSticky(ClearSticky), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .ResultOvf(ResultOvf), .StickyOvf(StickyOvf), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1; InValid = 0; Product = '0; ProductOvf = 0;
    Accumulate = 0; ClearSticky = 0; OutReady = 0;
    step(); step();
    Reset = 0;
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_resultovf", 32'(ResultOvf), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd1);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_sticky", 32'(StickyOvf), 32'd0);

    // Single load
    InValid = 1; Product = 32'd35; Accumulate = 0; OutReady = 1;
    step(); InValid = 0;
    chk("load_valid", 32'(OutValid), 32'd1);
    chk("load_result", Result, 32'd35);
    chk("load_ovf", 32'(ResultOvf), 32'd0);
    chk("load_count", 32'(Count), 32'd1);
    step();
    chk("load_popped_count", 32'(Count), 32'd0);
    chk("load_popped_valid", 32'(OutValid), 32'd0);

    // Accumulate chain 5, -7, 100
    InValid = 1; Product = 32'd5; Accumulate = 0;
    step();
    chk("chain_r0", Result, 32'd5);
    Product = -32'sd7; Accumulate = 1;
    step();
    chk("chain_r1", Result, 32'hFFFF_FFFE);
    chk("chain_ovf1", 32'(ResultOvf), 32'd0);
    chk("chain_count1", 32'(Count), 32'd1);
    Product = 32'd100;
    step(); InValid = 0;
    chk("chain_r2", Result, 32'd98);
    chk("chain_ovf2", 32'(ResultOvf), 32'd0);
    step();
    chk("chain_drained", 32'(Count), 32'd0);

    // Add overflow
    InValid = 1; Product = 32'h7FFF_FFFF; Accumulate = 0;
    step();
    chk("aovf_load", Result, 32'h7FFF_FFFF);
    chk("aovf_load_ovf", 32'(ResultOvf), 32'd0);
    Product = 32'd1; Accumulate = 1;
    step(); InValid = 0;
`ifdef MULT_ACC_SAT_EN
    chk("aovf_result", Result, 32'h7FFF_FFFF);
`else
    chk("aovf_result", Result, 32'h8000_0000);
`endif
    chk("aovf_ovf", 32'(ResultOvf), 32'd1);
    chk("aovf_sticky", 32'(StickyOvf), 32'd1);
    ClearSticky = 1;
    step(); ClearSticky = 0;
    chk("aovf_cleared", 32'(StickyOvf), 32'd0);
    chk("aovf_count", 32'(Count), 32'd0);

    // Backpressure: 10, 20, 30 offered with consumer stalled
    OutReady = 0; InValid = 1; Accumulate = 0; Product = 32'd10;
    step();
    chk("bp_count1", 32'(Count), 32'd1);
    chk("bp_ready1", 32'(InReady), 32'd1);
    Product = 32'd20;
    step();
    chk("bp_count2", 32'(Count), 32'd2);
    chk("bp_ready2", 32'(InReady), 32'd0);
    Product = 32'd30;
    step();
    chk("bp_held_count", 32'(Count), 32'd2);
    chk("bp_head10", Result, 32'd10);
    OutReady = 1;
    step();
    chk("bp_head20", Result, 32'd20);
    chk("bp_count_pop", 32'(Count), 32'd1);
    step(); InValid = 0;
    chk("bp_head30", Result, 32'd30);
    chk("bp_count_pp", 32'(Count), 32'd1);
    step();
    chk("bp_drained", 32'(Count), 32'd0);

    // Product overflow and sticky set-wins-over-clear
    OutReady = 0; InValid = 1; Product = 32'h8000_0000; ProductOvf = 1; Accumulate = 0;
    step();
    chk("povf_result", Result, 32'h8000_0000);
    chk("povf_ovf", 32'(ResultOvf), 32'd1);
    chk("povf_sticky", 32'(StickyOvf), 32'd1);
    Product = 32'd3; ClearSticky = 1;
    step(); InValid = 0; ProductOvf = 0;
    chk("povf_setwins", 32'(StickyOvf), 32'd1);
    chk("povf_count", 32'(Count), 32'd2);
    step(); ClearSticky = 0;
    chk("povf_clear", 32'(StickyOvf), 32'd0);
    OutReady = 1;
    step();
    chk("povf_second", Result, 32'd3);
    chk("povf_second_ovf", 32'(ResultOvf), 32'd1);
    step();
    chk("povf_drained", 32'(Count), 32'd0);

    // Reset mid-operation with Count=2, Acc=98, sticky set
    OutReady = 0; InValid = 1; Accumulate = 0; Product = 32'd100; ProductOvf = 1;
    step();
    ProductOvf = 0; Accumulate = 1; Product = -32'sd2;
    step(); InValid = 0;
    chk("mid_count", 32'(Count), 32'd2);
    chk("mid_sticky", 32'(StickyOvf), 32'd1);
    Reset = 1;
    step(); Reset = 0;
    chk("mrst_count", 32'(Count), 32'd0);
    chk("mrst_valid", 32'(OutValid), 32'd0);
    chk("mrst_result", Result, 32'd0);
    chk("mrst_sticky", 32'(StickyOvf), 32'd0);
    chk("mrst_ready", 32'(InReady), 32'd1);
    InValid = 1; Accumulate = 1; Product = 32'd4; OutReady = 1;
    step(); InValid = 0;
    chk("mrst_acc4", Result, 32'd4);
    chk("mrst_acc4_ovf", 32'(ResultOvf), 32'd0);
    step();
    chk("mrst_drained", 32'(Count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
